// File: rtl/circle_inv_fsm_32bit.sv
// circle_inv_fsm_32bit
// Round-trip decoder for the circle point generator. A unit-circle point
// (x,y) in signed Q16.16 is turned back into its angle fraction
// t = atan2(y,x)/2pi (Q0.32 turns) with a vectoring CORDIC, and t is then
// decoded into the sequence index k by inverting the van der Corput radical
// inverse in the selected base.
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     request, accepted only while ready=1
//   x_in      signed Q16.16 x coordinate, |x_in| < 2^30
//   y_in      signed Q16.16 y coordinate, |y_in| < 2^30
//   base_sel  radix select: 00=2, 01=3, 10=5, 11=7
//   k_out     decoded index
//   frac_out  angle fraction in turns, unsigned Q0.32
//   err       input vector was (0,0)
//   done      one-cycle pulse, results valid from this cycle
//   ready     high while idle and able to accept a request
module circle_inv_fsm_32bit #(
  parameter int ITER   = 16,
  parameter int DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [1:0]  base_sel,
  output logic [31:0] k_out,
  output logic [31:0] frac_out,
  output logic        err,
  output logic        done,
  output logic        ready
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CORDIC, S_DECODE, S_DONE} state_t;

  // Integer power used to size the decode bias at elaboration.
  function automatic longint ipow(input longint b, input int e);
    longint r;
    r = 64'sd1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Half an LSB of the last decoded digit, so truncation error in the
  // CORDIC angle cannot push t below a digit boundary.
  localparam logic [31:0] BIAS_B2 = 32'(64'sd2147483648 / ipow(64'sd2, DIGITS));
  localparam logic [31:0] BIAS_B3 = 32'(64'sd2147483648 / ipow(64'sd3, DIGITS));
  localparam logic [31:0] BIAS_B5 = 32'(64'sd2147483648 / ipow(64'sd5, DIGITS));
  localparam logic [31:0] BIAS_B7 = 32'(64'sd2147483648 / ipow(64'sd7, DIGITS));

  // round(atan(2^-i) / 2pi * 2^32): CORDIC rotation angles in turns.
  function automatic logic [31:0] atan_turns(input logic [4:0] i);
    logic [31:0] a;
    case (i)
      5'd0:  a = 32'h2000_0000;  5'd1:  a = 32'h12E4_051E;
      5'd2:  a = 32'h09FB_385B;  5'd3:  a = 32'h0511_11D4;
      5'd4:  a = 32'h028B_0D43;  5'd5:  a = 32'h0145_D7E1;
      5'd6:  a = 32'h00A2_F61E;  5'd7:  a = 32'h0051_7C55;
      5'd8:  a = 32'h0028_BE53;  5'd9:  a = 32'h0014_5F2F;
      5'd10: a = 32'h000A_2F98;  5'd11: a = 32'h0005_17CC;
      5'd12: a = 32'h0002_8BE6;  5'd13: a = 32'h0001_45F3;
      5'd14: a = 32'h0000_A2FA;  5'd15: a = 32'h0000_517D;
      5'd16: a = 32'h0000_28BE;  5'd17: a = 32'h0000_145F;
      5'd18: a = 32'h0000_0A30;  5'd19: a = 32'h0000_0518;
      5'd20: a = 32'h0000_028C;  5'd21: a = 32'h0000_0146;
      5'd22: a = 32'h0000_00A3;  5'd23: a = 32'h0000_0051;
      5'd24: a = 32'h0000_0029;  5'd25: a = 32'h0000_0014;
      5'd26: a = 32'h0000_000A;  5'd27: a = 32'h0000_0005;
      5'd28: a = 32'h0000_0003;  5'd29: a = 32'h0000_0001;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

  // t * base using only shifts and adds; the integer part lands in [35:32].
  function automatic logic [35:0] mul_base(input logic [31:0] v, input logic [1:0] sel);
    logic [35:0] w;
    logic [35:0] r;
    w = {4'd0, v};
    case (sel)
      2'd0:    r = w << 1'b1;
      2'd1:    r = (w << 1'b1) + w;
      2'd2:    r = (w << 2'd2) + w;
      2'd3:    r = (w << 2'd3) - w;
      default: r = w << 1'b1;
    endcase
    return r;
  endfunction

  state_t             state_r, state_n;
  logic signed [33:0] x_r, y_r, x_n, y_n;
  logic [31:0]        z_r, z_n;
  logic [31:0]        t_r, k_r, place_r;
  logic [1:0]         base_r;
  logic [4:0]         cnt_r;
  logic [31:0]        k_out_r, frac_out_r;
  logic               err_r, done_r, ready_r;
  logic [35:0]        p_s;
  logic [3:0]         digit_s;
  logic [31:0]        bias_s, base_val_s;
  logic               accept_s, cordic_last_s, decode_last_s, zero_in_s;

  assign accept_s      = start & ready_r;
  assign cordic_last_s = (cnt_r == 5'(ITER - 1));
  assign decode_last_s = (cnt_r == 5'(DIGITS - 1));
  assign zero_in_s     = (x_r == 34'sd0) && (y_r == 34'sd0);

  // One vectoring CORDIC micro-rotation driving y toward zero.
  always_comb begin
    x_n = x_r;
    y_n = y_r;
    z_n = z_r;
    if (!y_r[33]) begin
      x_n = x_r + (y_r >>> cnt_r);
      y_n = y_r - (x_r >>> cnt_r);
      z_n = z_r + atan_turns(cnt_r);
    end else begin
      x_n = x_r - (y_r >>> cnt_r);
      y_n = y_r + (x_r >>> cnt_r);
      z_n = z_r - atan_turns(cnt_r);
    end
  end

  // One radical-inverse digit: next digit of t in the captured base.
  always_comb begin
    p_s     = mul_base(t_r, base_r);
    digit_s = p_s[35:32];
    case (base_r)
      2'd0:    begin base_val_s = 32'd2; bias_s = BIAS_B2; end
      2'd1:    begin base_val_s = 32'd3; bias_s = BIAS_B3; end
      2'd2:    begin base_val_s = 32'd5; bias_s = BIAS_B5; end
      2'd3:    begin base_val_s = 32'd7; bias_s = BIAS_B7; end
      default: begin base_val_s = 32'd2; bias_s = BIAS_B2; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:   if (accept_s) state_n = S_PRE; else state_n = S_IDLE;
      S_PRE:    if (zero_in_s) state_n = S_DONE; else state_n = S_CORDIC;
      S_CORDIC: if (cordic_last_s) state_n = S_DECODE; else state_n = S_CORDIC;
      S_DECODE: if (decode_last_s) state_n = S_DONE; else state_n = S_DECODE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. done/ready trail the state by a cycle,
  // so ready stays low during the done cycle and rises right after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= 34'sd0;
      y_r        <= 34'sd0;
      z_r        <= 32'd0;
      t_r        <= 32'd0;
      k_r        <= 32'd0;
      place_r    <= 32'd1;
      base_r     <= 2'd0;
      cnt_r      <= 5'd0;
      k_out_r    <= 32'd0;
      frac_out_r <= 32'd0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      done_r  <= (state_r == S_DONE);
      ready_r <= (state_n == S_IDLE) && (state_r != S_DONE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            x_r    <= {{2{x_in[31]}}, x_in};
            y_r    <= {{2{y_in[31]}}, y_in};
            base_r <= base_sel;
          end
        end
        S_PRE: begin
          cnt_r <= 5'd0;
          k_r   <= 32'd0;
          if (zero_in_s) begin
            err_r      <= 1'b1;
            k_out_r    <= 32'd0;
            frac_out_r <= 32'd0;
          end else begin
            err_r <= 1'b0;
            // Fold the left half-plane onto the right; CORDIC converges only for |angle| < ~99 deg.
            if (x_r[33]) begin
              x_r <= -x_r;
              y_r <= -y_r;
              z_r <= 32'h8000_0000;
            end else begin
              z_r <= 32'd0;
            end
          end
        end
        S_CORDIC: begin
          x_r <= x_n;
          y_r <= y_n;
          z_r <= z_n;
          if (cordic_last_s) begin
            cnt_r      <= 5'd0;
            frac_out_r <= z_n;
            t_r        <= z_n + bias_s;
            k_r        <= 32'd0;
            place_r    <= 32'd1;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        S_DECODE: begin
          t_r     <= p_s[31:0];
          k_r     <= k_r + ({28'd0, digit_s} * place_r);
          place_r <= place_r * base_val_s;
          cnt_r   <= cnt_r + 5'd1;
        end
        S_DONE: begin
          k_out_r <= k_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign k_out    = k_out_r;
  assign frac_out = frac_out_r;
  assign err      = err_r;
  assign done     = done_r;
  assign ready    = ready_r;

endmodule

// File: tb/tb_circle_inv_fsm_32bit.sv
// Directed bench for circle_inv_fsm_32bit: known circle points with
// hand-derived indices and angle fractions, latency, zero vector, back-to-back
// requests, busy-time start, output hold and mid-operation reset.
module tb_circle_inv_fsm_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_in = 32'd0;
  logic [31:0] y_in = 32'd0;
  logic [1:0]  base_sel = 2'd0;
  logic [31:0] k_out, frac_out;
  logic        err, done, ready;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  b;
    logic [31:0] k;
    logic [31:0] f;
  } vec_t;

  vec_t vecs[11];

  circle_inv_fsm_32bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .base_sel(base_sel), .k_out(k_out), .frac_out(frac_out), .err(err),
    .done(done), .ready(ready)
  );

  always #5 clk = ~clk;

  // Angle distance modulo one turn within 2^17.
  function automatic logic near(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return (d < 32'h0002_0000) || (d > 32'hFFFE_0000);
  endfunction

  task automatic wait_ready(output int waited);
    waited = 0;
    while (ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Issue one request, then scramble the inputs and wait for done.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] b,
                        output int lat, output int waited);
    wait_ready(waited);
    x_in = x; y_in = y; base_sel = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; x_in = 32'h7FFF_0001; y_in = 32'h8000_1234; base_sel = ~b;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (k_out !== 32'd0 || frac_out !== 32'd0 || err !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: got k=%h f=%h err=%b done=%b ready=%b expected 0 0 0 0 1",
               k_out, frac_out, err, done, ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_points;
    int lat, waited;
    vecs[0]  = '{32'hFFFF_0000, 32'h0000_0000, 2'd0, 32'd1, 32'h8000_0000};
    vecs[1]  = '{32'h0000_0000, 32'h0001_0000, 2'd0, 32'd2, 32'h4000_0000};
    vecs[2]  = '{32'h0000_0000, 32'hFFFF_0000, 2'd0, 32'd3, 32'hC000_0000};
    vecs[3]  = '{32'h0000_B505, 32'h0000_B505, 2'd0, 32'd4, 32'h2000_0000};
    vecs[4]  = '{32'hFFFF_8000, 32'h0000_DDB4, 2'd1, 32'd1, 32'h5555_5555};
    vecs[5]  = '{32'hFFFF_8000, 32'hFFFF_224C, 2'd1, 32'd2, 32'hAAAA_AAAB};
    vecs[6]  = '{32'd82951118,  32'd255297290, 2'd2, 32'd1, 32'h3333_3333};
    vecs[7]  = '{32'd167366770, 32'd209871295, 2'd3, 32'd1, 32'h2492_4925};
    vecs[8]  = '{32'h1000_0000, 32'h0000_0000, 2'd3, 32'd0, 32'h0000_0000};
    vecs[9]  = '{32'h0001_0000, 32'hFFFF_FFFF, 2'd0, 32'd0, 32'hFFFF_FFFF};
    vecs[10] = '{32'h0000_0000, 32'h0010_0000, 2'd0, 32'd2, 32'h4000_0000};
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].b, lat, waited);
      checks++;
      if (lat >= 60 || waited >= 50) begin
        failures++;
        $display("FAIL vec%0d timeout: got lat=%0d wait=%0d expected done within 60", i, lat, waited);
      end
      checks++;
      if (k_out !== vecs[i].k) begin
        failures++;
        $display("FAIL vec%0d k_out: got %0d expected %0d", i, k_out, vecs[i].k);
      end
      checks++;
      if (!near(frac_out, vecs[i].f)) begin
        failures++;
        $display("FAIL vec%0d frac_out: got %h expected %h +/-2^17", i, frac_out, vecs[i].f);
      end
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d err: got %b expected 0", i, err);
      end
    end
  endtask

  task automatic test_latency_and_hold;
    int lat, waited;
    run_op(32'h0000_0000, 32'hFFFF_0000, 2'd0, lat, waited);
    checks++;
    if (lat !== 23) begin
      failures++;
      $display("FAIL latency: got %0d expected 23", lat);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (k_out !== 32'd3 || !near(frac_out, 32'hC000_0000) || done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL hold: got k=%0d f=%h done=%b ready=%b expected 3 ~c0000000 0 1",
               k_out, frac_out, done, ready);
    end
  endtask

  task automatic test_zero;
    int lat, waited;
    run_op(32'h0000_0000, 32'h0000_0000, 2'd0, lat, waited);
    checks++;
    if (lat > 3) begin
      failures++;
      $display("FAIL zero_latency: got %0d expected at most 3", lat);
    end
    checks++;
    if (err !== 1'b1 || k_out !== 32'd0 || frac_out !== 32'd0) begin
      failures++;
      $display("FAIL zero_result: got err=%b k=%0d f=%h expected 1 0 0", err, k_out, frac_out);
    end
    run_op(32'h0000_B505, 32'h0000_B505, 2'd0, lat, waited);
    checks++;
    if (err !== 1'b0 || k_out !== 32'd4) begin
      failures++;
      $display("FAIL err_clear: got err=%b k=%0d expected 0 4", err, k_out);
    end
  endtask

  task automatic test_back_to_back;
    int lat, waited;
    run_op(32'hFFFF_0000, 32'h0000_0000, 2'd0, lat, waited);
    run_op(32'hFFFF_8000, 32'hFFFF_224C, 2'd1, lat, waited);
    checks++;
    if (waited !== 1) begin
      failures++;
      $display("FAIL b2b_ready: got ready after %0d cycles expected 1", waited);
    end
    checks++;
    if (k_out !== 32'd2 || lat !== 23) begin
      failures++;
      $display("FAIL b2b_result: got k=%0d lat=%0d expected 2 23", k_out, lat);
    end
  endtask

  task automatic test_busy;
    int waited, pulses, highs;
    logic prev;
    wait_ready(waited);
    x_in = 32'h0000_0000; y_in = 32'h0001_0000; base_sel = 2'd0; start = 1'b1;
    pulses = 0; highs = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 59) start = 1'b0;
      if (done === 1'b1) highs++;
      if (done === 1'b1 && !prev) pulses++;
      prev = done;
    end
    checks++;
    if (pulses !== 3 || highs !== 3) begin
      failures++;
      $display("FAIL busy_start: got pulses=%0d high_cycles=%0d expected 3 3", pulses, highs);
    end
    checks++;
    if (k_out !== 32'd2) begin
      failures++;
      $display("FAIL busy_result: got k=%0d expected 2", k_out);
    end
  endtask

  task automatic test_reset_mid;
    int lat, waited, dones;
    run_op(32'h0000_0000, 32'hFFFF_0000, 2'd0, lat, waited);
    wait_ready(waited);
    x_in = 32'h0000_B505; y_in = 32'h0000_B505; base_sel = 2'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (k_out !== 32'd0 || frac_out !== 32'd0 || err !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got k=%h f=%h err=%b done=%b ready=%b expected 0 0 0 0 1",
               k_out, frac_out, err, done, ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || ready !== 1'b1 || k_out !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_abort: got dones=%0d ready=%b k=%0d expected 0 1 0", dones, ready, k_out);
    end
  endtask

  initial begin
    test_reset;
    test_points;
    test_latency_and_hold;
    test_zero;
    test_back_to_back;
    test_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
